// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes,
// flag bit positions and the architectural flag word type.
package cond_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_t;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef logic [3:0] flags_t;

   // Signed greater-or-equal: N and V agree.
   function automatic logic flag_ge(input flags_t f);
      return ~(f[FLAG_N] ^ f[FLAG_V]);
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluation: Cond + current flags -> CondEx.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v, ge;

   assign n  = Flags[FLAG_N];
   assign z  = Flags[FLAG_Z];
   assign c  = Flags[FLAG_C];
   assign v  = Flags[FLAG_V];
   assign ge = flag_ge(Flags);

   // Standard ARM condition table; NV never executes.
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = ge;
         COND_LT: CondEx = ~ge;
         COND_GT: CondEx = ~z & ge;
         COND_LE: CondEx = z | ~ge;
         COND_AL: CondEx = 1'b1;
         COND_NV: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: architectural flag register, write-enable
// gating and a small LIFO of saved flag contexts for exception nesting.
module cond_unit
   import cond_pkg::*;
#(
   parameter int unsigned STACK_DEPTH   = 4,
   parameter int unsigned GATE_ON_STALL = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             en,
   input  logic [3:0]                       Cond,
   input  logic [3:0]                       ALUFlags,
   input  logic [1:0]                       FlagW,
   input  logic                             PCS,
   input  logic                             RegW,
   input  logic                             MemW,
   input  logic                             NoWrite,
   input  logic                             push,
   input  logic                             pop,
   output logic                             PCSrc,
   output logic                             RegWrite,
   output logic                             MemWrite,
   output logic                             CondEx,
   output logic [3:0]                       Flags,
   output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
   output logic                             ovf_err,
   output logic                             unf_err
);

   localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

   flags_t          flags_q, flags_d;
   logic [DW-1:0]   depth_q, depth_d;
   logic            ovf_q, ovf_d, unf_q, unf_d;
   logic            push_we;
   logic [AW-1:0]   wr_idx, rd_idx;
   logic            condex;
   logic            gate;

   // Power-of-two sized so the pointer slice always indexes in range.
   flags_t          stack_mem [2**AW];

   cond_eval u_eval (
      .Cond   (Cond),
      .Flags  (flags_q),
      .CondEx (condex)
   );

   assign gate     = (GATE_ON_STALL != 0) ? en : 1'b1;
   assign CondEx   = condex;
   assign PCSrc    = PCS  & condex & gate;
   assign MemWrite = MemW & condex & gate;
   assign RegWrite = RegW & condex & ~NoWrite & gate;
   assign Flags    = flags_q;
   assign depth    = depth_q;
   assign ovf_err  = ovf_q;
   assign unf_err  = unf_q;

   assign wr_idx = AW'(depth_q);
   assign rd_idx = AW'(depth_q - 1'b1);

   // Next flag/stack state: flag write first, then a successful pop overrides
   // it, and an overflowing push suppresses the flag write entirely.
   always_comb begin
      flags_d = flags_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_we = 1'b0;
      if (en) begin
         if (condex && !(push && !pop && depth_q == DEPTH_MAX)) begin
            if (FlagW[1]) begin
               flags_d[FLAG_N] = ALUFlags[FLAG_N];
               flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
               flags_d[FLAG_C] = ALUFlags[FLAG_C];
               flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
         end
         if (push && !pop) begin
            if (depth_q == DEPTH_MAX) begin
               ovf_d = 1'b1;
            end else begin
               push_we = 1'b1;
               depth_d = depth_q + 1'b1;
            end
         end
         if (pop && !push) begin
            if (depth_q == '0) begin
               unf_d = 1'b1;
            end else begin
               flags_d = stack_mem[rd_idx];
               depth_d = depth_q - 1'b1;
            end
         end
      end
   end

   // Architectural state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Context storage saves the pre-write flags; contents need no reset.
   always_ff @(posedge clk) begin
      if (!reset && push_we) begin
         stack_mem[wr_idx] <= flags_q;
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized
// traffic compared each cycle against a queue-based behavioural model.
module tb_cond_unit;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset, en, pcs, regw, memw, nowrite, push, pop;
   logic [3:0] cond, aluflags;
   logic [1:0] flagw;
   logic       pcsrc, regwrite, memwrite, condex, ovf_err, unf_err;
   logic [3:0] flags;
   logic [2:0] depth;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // model state
   logic [3:0] m_flags = 4'b0000;
   logic [3:0] m_stack [$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   cond_unit #(.STACK_DEPTH(DEPTH), .GATE_ON_STALL(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .Cond     (cond),
      .ALUFlags (aluflags),
      .FlagW    (flagw),
      .PCS      (pcs),
      .RegW     (regw),
      .MemW     (memw),
      .NoWrite  (nowrite),
      .push     (push),
      .pop      (pop),
      .PCSrc    (pcsrc),
      .RegWrite (regwrite),
      .MemWrite (memwrite),
      .CondEx   (condex),
      .Flags    (flags),
      .depth    (depth),
      .ovf_err  (ovf_err),
      .unf_err  (unf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ARM rule: Cond[3:1] picks a predicate, Cond[0] negates it; 1111 never.
   function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, r;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cy;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cy && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? !r : r;
   endfunction

   // One cycle: check all outputs against the model, then advance both.
   task automatic tick();
      logic       cx, full;
      logic [3:0] nf;
      #1;
      cx = m_cond(cond, m_flags);
      check("condex",   condex,   cx);
      check("pcsrc",    pcsrc,    pcs  & cx & en);
      check("memwrite", memwrite, memw & cx & en);
      check("regwrite", regwrite, regw & cx & ~nowrite & en);
      check("flags",    flags,    m_flags);
      check("depth",    depth,    m_stack.size());
      check("ovf_err",  ovf_err,  m_ovf);
      check("unf_err",  unf_err,  m_unf);
      @(posedge clk);
      if (reset) begin
         m_flags = 4'b0000;
         m_stack.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (en) begin
         full = (m_stack.size() == DEPTH);
         nf = m_flags;
         if (cx && !(push && !pop && full)) begin
            if (flagw[1]) nf[3:2] = aluflags[3:2];
            if (flagw[0]) nf[1:0] = aluflags[1:0];
         end
         if (push && !pop) begin
            if (full) m_ovf = 1'b1;
            else m_stack.push_back(m_flags);
         end
         if (pop && !push) begin
            if (m_stack.size() == 0) m_unf = 1'b1;
            else nf = m_stack.pop_back();
         end
         m_flags = nf;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 0; en = 1; cond = 4'hE; aluflags = 0; flagw = 0;
      pcs = 0; regw = 0; memw = 0; nowrite = 0; push = 0; pop = 0;
   endtask

   task automatic set_flags(input logic [3:0] f);
      idle(); flagw = 2'b11; aluflags = f; tick();
   endtask

   initial begin
      logic [3:0] vals [4];
      vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;

      idle(); reset = 1;
      @(negedge clk);
      tick(); tick();

      // reset state, AL with RegW
      idle(); regw = 1; #1;
      check("rst_regwrite", regwrite, 1'b1);
      check("rst_flags", flags, 4'b0000);
      check("rst_depth", depth, 3'd0);
      tick();

      // Z set, then EQ/NE steer PCSrc
      set_flags(4'b0100);
      idle(); cond = 4'h0; pcs = 1; #1;
      check("eq_pcsrc", pcsrc, 1'b1);
      tick();
      idle(); cond = 4'h1; pcs = 1; #1;
      check("ne_pcsrc", pcsrc, 1'b0);
      tick();

      // LT passes, C/V write lands; GT fails, flags hold
      set_flags(4'b1000);
      idle(); cond = 4'hB; flagw = 2'b01; aluflags = 4'b0011; #1;
      check("lt_condex", condex, 1'b1);
      tick();
      check("lt_flags", flags, 4'b1011);
      set_flags(4'b1000);
      idle(); cond = 4'hC; flagw = 2'b01; aluflags = 4'b0011; #1;
      check("gt_condex", condex, 1'b0);
      tick();
      check("gt_flags", flags, 4'b1000);

      // fill stack past capacity, then unwind LIFO
      idle(); reset = 1; tick();
      for (int i = 0; i < 5; i++) begin
         idle(); push = 1; flagw = 2'b11; aluflags = vals[i % 4]; tick();
      end
      check("ovf_depth", depth, 3'd4);
      check("ovf_set", ovf_err, 1'b1);
      check("ovf_flags", flags, vals[3]);
      for (int i = 2; i >= -1; i--) begin
         idle(); pop = 1; tick();
         check("pop_lifo", flags, (i >= 0) ? vals[i] : 4'b0000);
      end
      idle(); pop = 1; tick();
      check("unf_set", unf_err, 1'b1);
      check("unf_flags", flags, 4'b0000);

      // push with same-cycle write, then pop overrides write
      set_flags(4'b1001);
      idle(); push = 1; flagw = 2'b11; aluflags = 4'b0110; tick();
      check("pushw_flags", flags, 4'b0110);
      check("pushw_depth", depth, 3'd1);
      idle(); pop = 1; flagw = 2'b11; aluflags = 4'b1111; tick();
      check("popw_flags", flags, 4'b1001);

      // stall blocks everything
      idle(); en = 0; push = 1; flagw = 2'b11; aluflags = 4'b0101; memw = 1; #1;
      check("stall_memwrite", memwrite, 1'b0);
      tick();
      check("stall_flags", flags, 4'b1001);
      check("stall_depth", depth, 3'd0);

      // reset mid-nesting discards contexts
      idle(); push = 1; tick();
      idle(); push = 1; tick();
      idle(); reset = 1; push = 1; flagw = 2'b11; aluflags = 4'b1111; tick();
      check("rstnest_depth", depth, 3'd0);
      check("rstnest_flags", flags, 4'b0000);
      check("rstnest_ovf", ovf_err, 1'b0);
      check("rstnest_unf", unf_err, 1'b0);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         reset    = ($urandom_range(0, 99) == 0);
         en       = ($urandom_range(0, 7) != 0);
         cond     = 4'($urandom);
         aluflags = 4'($urandom);
         flagw    = 2'($urandom);
         pcs      = 1'($urandom);
         regw     = 1'($urandom);
         memw     = 1'($urandom);
         nowrite  = 1'($urandom);
         push     = ($urandom_range(0, 2) == 0);
         pop      = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, meaning number of saved flag contexts (legal range 1..16).
REQ-002 SHALL have parameter GATE_ON_STALL, default 1; when 1, en=0 forces all write enables low.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 en  input  1  stage enable; 0 means stall, with no state change.
REQ-006 Cond  input  4  ARM condition field (EQ..AL, 1111=NV).
REQ-007 ALUFlags  input  4  {N,Z,C,V} from ALU.
REQ-008 FlagW  input  2  bit1 writes N,Z; bit0 writes C,V.
REQ-009 PCS, RegW, MemW  input  1 each  ungated decoder requests.
REQ-010 NoWrite  input  1  suppresses RegWrite (CMP/TST class).
REQ-011 push, pop  input  1 each  save or restore flag context (exception entry/return).
REQ-012 PCSrc, RegWrite, MemWrite  output  1 each  gated enables.
REQ-013 CondEx  output  1  condition passed.
REQ-014 Flags  output  4  current architectural {N,Z,C,V}.
REQ-015 depth  output  $clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-016 ovf_err, unf_err  output  1 each  sticky overflow/underflow flags.

Function
REQ-017 CondEx SHALL be combinational from Cond and the Flags register, with zero latency, using GE = ~(N^V) and the standard ARM table.
REQ-018 Cond=1110 SHALL give CondEx=1, and Cond=1111 (NV) SHALL give CondEx=0.
REQ-019 PCSrc=PCS&CondEx, MemWrite=MemW&CondEx, and RegWrite=RegW&CondEx&~NoWrite, each further ANDed with en when GATE_ON_STALL=1.
REQ-020 On a rising edge with en=1 and CondEx=1, FlagW[1] SHALL load N,Z from ALUFlags and FlagW[0] SHALL load C,V; unselected bits hold.
REQ-021 A failed condition (CondEx=0) SHALL leave Flags unchanged regardless of FlagW.
REQ-022 Flag-write results SHALL become visible on Flags and CondEx one cycle after the write edge.
REQ-023 A push with en=1 and depth<STACK_DEPTH SHALL store the pre-write Flags at the top of the stack and increment depth; a same-cycle flag write still updates Flags.
REQ-024 A pop with en=1 and depth>0 SHALL load Flags from the top entry and decrement depth; the pop overrides any same-cycle flag write.
REQ-025 A push at depth=STACK_DEPTH SHALL be dropped, leave Flags and depth unchanged, and set ovf_err.
REQ-026 A pop at depth=0 SHALL be ignored (the normal flag write proceeds) and set unf_err.
REQ-027 push and pop asserted together SHALL leave the stack and depth unchanged, set no error, and let the normal flag write proceed.
REQ-028 ovf_err and unf_err SHALL stay set until reset.
REQ-029 With en=0, Flags, the stack, depth and the error bits SHALL hold, whatever push, pop or FlagW are.

Reset
REQ-030 Reset SHALL set Flags=4'b0000, depth=0, ovf_err=0 and unf_err=0; stack contents are don't-care.
REQ-031 Reset SHALL take priority over en, push, pop and FlagW in the same cycle, and a reset mid-nesting SHALL discard all saved contexts.
REQ-032 During reset, outputs SHALL follow REQ-017..019 from the reset Flags value; with Flags=0, Cond=EQ gives CondEx=0.

Structure
REQ-033 Shared package cond_pkg SHALL hold the 4-bit condition-code constants (COND_EQ..COND_NV), the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and the flags_t typedef.
REQ-034 Condition evaluation SHALL live in one combinational sub-module, cond_eval (Cond, Flags -> CondEx); the register, stack and gating SHALL live in cond_unit.

Verification
REQ-035 Reset, then Cond=1110, RegW=1 -> RegWrite=1, Flags=0000, depth=0.
REQ-036 ALUFlags=0100, FlagW=11, Cond=AL; next cycle Cond=EQ, PCS=1 -> PCSrc=1; Cond=NE -> PCSrc=0.
REQ-037 Flags=1000, Cond=LT, FlagW=01, ALUFlags=0011 -> CondEx=1, then Flags=1011; with Cond=GT (CondEx=0) instead, Flags stays 1000.
REQ-038 STACK_DEPTH=4: push 5 times with distinct Flags -> depth=4 and ovf_err=1; then pop 4 times -> the 4 saved values return LIFO; a 5th pop -> unf_err=1 and Flags unchanged.
REQ-039 push with FlagW=11 and ALUFlags=0110 in the same cycle -> stack top holds the old Flags, Flags=0110; a later pop with FlagW=11 -> Flags = the popped value.
REQ-040 en=0 with push=1, FlagW=11, MemW=1, Cond=AL -> MemWrite=0, and Flags and depth are unchanged next cycle.
